// File: rtl/mae_pkg.sv
// mae_pkg: operand/result widths, signed datapath types and the
// configuration legality check shared by the soft MAE cell.
package mae_pkg;

  localparam int A_W    = 18;
  localparam int B_W    = 18;
  localparam int PROD_W = 36;
  localparam int P_W    = 40;

  typedef logic signed [A_W-1:0]    a_t;
  typedef logic signed [B_W-1:0]    b_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [P_W-1:0]    p_t;

  // Feedback only makes sense when the post-adder exists and P is a register.
  function automatic bit legal_cfg(input int use_feedback,
                                   input int post_adder_static,
                                   input int bypass_p);
    return (use_feedback == 0) || ((post_adder_static != 0) && (bypass_p != 0));
  endfunction

endpackage

// File: rtl/mae_opt_reg.sv
// mae_opt_reg: optional pipeline register. PRESENT=1 gives an enabled,
// asynchronously cleared register; PRESENT=0 makes it a plain wire.
module mae_opt_reg import mae_pkg::*; #(
  parameter int DATA_W  = 1,
  parameter int PRESENT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q_r <= '0;
    else if (en) q_r <= d;
  end

  assign q = (PRESENT != 0) ? q_r : d;

endmodule

// File: rtl/mae_soft_macc.sv
// mae_soft_macc: fabric implementation of the MAE multiply/add/accumulate
// cell with optional A/B/C input, product and P output registers and a
// valid bit that travels with the data.
// Build option: define MAE_ACC_SAT_EN to saturate the post-adder on signed
// overflow and expose a sticky STATUS_SAT flag; otherwise the sum wraps.
module mae_soft_macc import mae_pkg::*; #(
  parameter int BYPASS_A          = 0,
  parameter int BYPASS_B          = 0,
  parameter int BYPASS_C          = 0,
  parameter int BYPASS_P          = 0,
  parameter int MULT_HAS_REG      = 0,
  parameter int POST_ADDER_STATIC = 0,
  parameter int USE_FEEDBACK      = 0
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic signed [A_W-1:0] A,
  input  logic signed [B_W-1:0] B,
  input  logic signed [P_W-1:0] C,
  input  logic                  A_EN,
  input  logic                  B_EN,
  input  logic                  C_EN,
  input  logic                  P_EN,
  input  logic                  CDIN_FDBK_SEL,
  input  logic                  IN_VALID,
  output logic signed [P_W-1:0] P,
  output logic                  OUT_VALID
`ifdef MAE_ACC_SAT_EN
  ,
  output logic                  STATUS_SAT
`endif
);

  if (!legal_cfg(USE_FEEDBACK, POST_ADDER_STATIC, BYPASS_P)) begin : g_bad_cfg
    $error("mae_soft_macc: USE_FEEDBACK=1 needs POST_ADDER_STATIC=1 and BYPASS_P=1");
  end

`ifdef MAE_ACC_SAT_EN
  localparam p_t P_MAX = {1'b0, {(P_W-1){1'b1}}};
  localparam p_t P_MIN = {1'b1, {(P_W-1){1'b0}}};

  function automatic logic add_ovf(input p_t x, input p_t y);
    p_t s;
    s = x + y;
    return (x[P_W-1] == y[P_W-1]) && (s[P_W-1] != x[P_W-1]);
  endfunction

  function automatic p_t add_sat(input p_t x, input p_t y);
    if (add_ovf(x, y)) return x[P_W-1] ? P_MIN : P_MAX;
    return x + y;
  endfunction
`endif

  a_t    a_p0;
  b_t    b_p0;
  p_t    c_p0;
  logic  vld_p0;
  prod_t prod_d;
  prod_t prod_p1;
  logic  vld_p1;
  p_t    prod_ext;
  p_t    p_fb;
  p_t    addend;
  p_t    sum_p2;
  p_t    p_p3;
  logic  vld_p3;
`ifdef MAE_ACC_SAT_EN
  logic  sat_hit;
`endif

  // Stage 1: input registers; valid advances only when both operands load
  mae_opt_reg #(.DATA_W(A_W), .PRESENT(BYPASS_A)) u_a_reg (
    .clk(CLK), .rst(reset), .en(A_EN), .d(A), .q(a_p0));
  mae_opt_reg #(.DATA_W(B_W), .PRESENT(BYPASS_B)) u_b_reg (
    .clk(CLK), .rst(reset), .en(B_EN), .d(B), .q(b_p0));
  mae_opt_reg #(.DATA_W(P_W), .PRESENT(BYPASS_C)) u_c_reg (
    .clk(CLK), .rst(reset), .en(C_EN), .d(C), .q(c_p0));
  mae_opt_reg #(.DATA_W(1), .PRESENT(BYPASS_A)) u_vld0_reg (
    .clk(CLK), .rst(reset), .en(A_EN & B_EN), .d(IN_VALID), .q(vld_p0));

  // Stage 2: signed 18x18 product, optional free-running register
  assign prod_d = a_p0 * b_p0;

  mae_opt_reg #(.DATA_W(PROD_W), .PRESENT(MULT_HAS_REG)) u_prod_reg (
    .clk(CLK), .rst(reset), .en(1'b1), .d(prod_d), .q(prod_p1));
  mae_opt_reg #(.DATA_W(1), .PRESENT(MULT_HAS_REG)) u_vld1_reg (
    .clk(CLK), .rst(reset), .en(1'b1), .d(vld_p0), .q(vld_p1));

  // Stage 3: post-adder; feedback always sees the registered P
  assign prod_ext = {{(P_W-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};

  if (USE_FEEDBACK != 0) begin : g_fb
    assign p_fb = p_p3;
  end else begin : g_no_fb
    assign p_fb = '0;
  end

  always_comb begin
    addend = c_p0;
    sum_p2 = prod_ext;
`ifdef MAE_ACC_SAT_EN
    sat_hit = 1'b0;
`endif
    if ((USE_FEEDBACK != 0) && !CDIN_FDBK_SEL) addend = p_fb;
    if (POST_ADDER_STATIC != 0) begin
`ifdef MAE_ACC_SAT_EN
      sum_p2  = add_sat(prod_ext, addend);
      sat_hit = add_ovf(prod_ext, addend);
`else
      sum_p2  = prod_ext + addend;
`endif
    end
  end

  // Stage 4: output register, paused by P_EN
  mae_opt_reg #(.DATA_W(P_W), .PRESENT(BYPASS_P)) u_p_reg (
    .clk(CLK), .rst(reset), .en(P_EN), .d(sum_p2), .q(p_p3));
  mae_opt_reg #(.DATA_W(1), .PRESENT(BYPASS_P)) u_vld3_reg (
    .clk(CLK), .rst(reset), .en(P_EN), .d(vld_p1), .q(vld_p3));

  assign P         = p_p3;
  assign OUT_VALID = vld_p3;

`ifdef MAE_ACC_SAT_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                                   STATUS_SAT <= 1'b0;
    else if (sat_hit && ((BYPASS_P == 0) || P_EN)) STATUS_SAT <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mae_soft_macc.sv
// tb_mae_soft_macc: four configurations of mae_soft_macc driven from shared
// inputs: [0] fully combinational multiply, [1] A/B + product + P registers,
// [2] post-adder with registered C, [3] accumulator with feedback.
module tb_mae_soft_macc;

  localparam longint MAXP = (longint'(1) <<< 39) - 1;
  localparam longint MINP = -(longint'(1) <<< 39);

  logic               CLK = 1'b0;
  logic               reset = 1'b1;
  logic signed [17:0] A = '0;
  logic signed [17:0] B = '0;
  logic signed [39:0] C = '0;
  logic               A_EN = 1'b0, B_EN = 1'b0, C_EN = 1'b0, P_EN = 1'b0;
  logic               CDIN_FDBK_SEL = 1'b0, IN_VALID = 1'b0;
  logic signed [39:0] p_o  [4];
  logic               ov_o [4];
`ifdef MAE_ACC_SAT_EN
  logic               sat_o [4];
`endif

  int n_pass  = 0;
  int n_total = 0;

  // reference state
  longint             pq[$];
  bit                 vq[$];
  logic signed [39:0] c_held;
  logic signed [39:0] acc_p;
  bit                 acc_v;

  always #5 CLK = ~CLK;

  mae_soft_macc #(.BYPASS_A(0), .BYPASS_B(0), .BYPASS_C(0), .BYPASS_P(0),
                  .MULT_HAS_REG(0), .POST_ADDER_STATIC(0), .USE_FEEDBACK(0)) u_comb (
    .CLK(CLK), .reset(reset), .A(A), .B(B), .C(C), .A_EN(A_EN), .B_EN(B_EN),
    .C_EN(C_EN), .P_EN(P_EN), .CDIN_FDBK_SEL(CDIN_FDBK_SEL), .IN_VALID(IN_VALID),
    .P(p_o[0]), .OUT_VALID(ov_o[0])
`ifdef MAE_ACC_SAT_EN
    , .STATUS_SAT(sat_o[0])
`endif
  );

  mae_soft_macc #(.BYPASS_A(1), .BYPASS_B(1), .BYPASS_C(0), .BYPASS_P(1),
                  .MULT_HAS_REG(1), .POST_ADDER_STATIC(0), .USE_FEEDBACK(0)) u_pipe (
    .CLK(CLK), .reset(reset), .A(A), .B(B), .C(C), .A_EN(A_EN), .B_EN(B_EN),
    .C_EN(C_EN), .P_EN(P_EN), .CDIN_FDBK_SEL(CDIN_FDBK_SEL), .IN_VALID(IN_VALID),
    .P(p_o[1]), .OUT_VALID(ov_o[1])
`ifdef MAE_ACC_SAT_EN
    , .STATUS_SAT(sat_o[1])
`endif
  );

  mae_soft_macc #(.BYPASS_A(0), .BYPASS_B(0), .BYPASS_C(1), .BYPASS_P(0),
                  .MULT_HAS_REG(0), .POST_ADDER_STATIC(1), .USE_FEEDBACK(0)) u_padd (
    .CLK(CLK), .reset(reset), .A(A), .B(B), .C(C), .A_EN(A_EN), .B_EN(B_EN),
    .C_EN(C_EN), .P_EN(P_EN), .CDIN_FDBK_SEL(CDIN_FDBK_SEL), .IN_VALID(IN_VALID),
    .P(p_o[2]), .OUT_VALID(ov_o[2])
`ifdef MAE_ACC_SAT_EN
    , .STATUS_SAT(sat_o[2])
`endif
  );

  mae_soft_macc #(.BYPASS_A(0), .BYPASS_B(0), .BYPASS_C(0), .BYPASS_P(1),
                  .MULT_HAS_REG(0), .POST_ADDER_STATIC(1), .USE_FEEDBACK(1)) u_acc (
    .CLK(CLK), .reset(reset), .A(A), .B(B), .C(C), .A_EN(A_EN), .B_EN(B_EN),
    .C_EN(C_EN), .P_EN(P_EN), .CDIN_FDBK_SEL(CDIN_FDBK_SEL), .IN_VALID(IN_VALID),
    .P(p_o[3]), .OUT_VALID(ov_o[3])
`ifdef MAE_ACC_SAT_EN
    , .STATUS_SAT(sat_o[3])
`endif
  );

  function automatic longint prod(input logic signed [17:0] a, input logic signed [17:0] b);
    return longint'(a) * longint'(b);
  endfunction

  // 40-bit signed add: clamps to the signed range when saturation is built in
  function automatic logic signed [39:0] post_add(input logic signed [39:0] x,
                                                  input logic signed [39:0] y);
    longint s;
    s = longint'(x) + longint'(y);
`ifdef MAE_ACC_SAT_EN
    if (s > MAXP) s = MAXP;
    if (s < MINP) s = MINP;
`endif
    return s[39:0];
  endfunction

  task automatic model_clear();
    pq = '{0, 0, 0};
    vq = '{0, 0, 0};
    c_held = '0;
    acc_p  = '0;
    acc_v  = 1'b0;
  endtask

  // advance one clock; the reference consumes the inputs present at the edge
  task automatic tick();
    logic signed [39:0] pr;
    pr = 40'(prod(A, B));
    pq.push_back(prod(A, B));
    vq.push_back(IN_VALID);
    void'(pq.pop_front());
    void'(vq.pop_front());
    if (C_EN) c_held = C;
    if (P_EN) begin
      acc_p = post_add(pr, CDIN_FDBK_SEL ? C : acc_p);
      acc_v = IN_VALID;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    A = '0; B = '0; C = '0;
    A_EN = 0; B_EN = 0; C_EN = 0; P_EN = 0; CDIN_FDBK_SEL = 0; IN_VALID = 0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    #1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (p_o[i] !== 40'sd0) $display("FAIL reset_p[%0d]: got %0d expected 0", i, p_o[i]);
      else n_pass++;
      n_total++;
      if (ov_o[i] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b expected 0", i, ov_o[i]);
      else n_pass++;
`ifdef MAE_ACC_SAT_EN
      n_total++;
      if (sat_o[i] !== 1'b0) $display("FAIL reset_sat[%0d]: got %b expected 0", i, sat_o[i]);
      else n_pass++;
`endif
    end
    @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_comb_multiply();
    logic signed [17:0] av [4];
    logic signed [17:0] bv [4];
    av = '{18'sd3, -18'sd131072, 18'sd131071, -18'sd1};
    bv = '{-18'sd5, -18'sd131072, -18'sd131072, 18'sd1};
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin
        A = av[i]; B = bv[i]; IN_VALID = 1'b1;
      end else begin
        A = 18'($urandom); B = 18'($urandom); IN_VALID = 1'($urandom_range(0, 1));
      end
      #1;
      n_total++;
      if (p_o[0] !== 40'(prod(A, B)))
        $display("FAIL comb_p: A=%0d B=%0d got %0d expected %0d", A, B, p_o[0], prod(A, B));
      else n_pass++;
      n_total++;
      if (ov_o[0] !== IN_VALID) $display("FAIL comb_valid: got %b expected %b", ov_o[0], IN_VALID);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_pipeline();
    do_reset();
    A_EN = 1; B_EN = 1; C_EN = 1; P_EN = 1;
    A = 18'sd131071; B = 18'sd131071; IN_VALID = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      n_total++;
      if (ov_o[1] !== (k == 3)) $display("FAIL pipe_pulse_valid cycle %0d: got %b expected %b", k, ov_o[1], (k == 3));
      else n_pass++;
      if (k == 3) begin
        n_total++;
        if (p_o[1] !== 40'sd17179607041) $display("FAIL pipe_pulse_p: got %0d expected 17179607041", p_o[1]);
        else n_pass++;
      end
      IN_VALID = 1'b0; A = 18'($urandom); B = 18'($urandom);
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      n_total++;
      if (p_o[1] !== 40'(pq[0]) || ov_o[1] !== vq[0])
        $display("FAIL pipe_stream: got p=%0d v=%b expected p=%0d v=%b", p_o[1], ov_o[1], pq[0], vq[0]);
      else n_pass++;
      A = 18'($urandom); B = 18'($urandom); IN_VALID = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic test_mixed_enables();
    do_reset();
    P_EN = 1;
    A = 18'sd5; B = 18'sd7; A_EN = 1; B_EN = 1; IN_VALID = 1;
    tick();
    A = 18'sd11; B = 18'sd100; A_EN = 1; B_EN = 0; IN_VALID = 0;
    tick();
    A_EN = 0;
    tick();
    n_total++;
    if (p_o[1] !== 40'sd35 || ov_o[1] !== 1'b1) $display("FAIL mixed_first: got p=%0d v=%b expected p=35 v=1", p_o[1], ov_o[1]);
    else n_pass++;
    tick();
    n_total++;
    if (p_o[1] !== 40'sd77 || ov_o[1] !== 1'b1) $display("FAIL mixed_pair: got p=%0d v=%b expected p=77 v=1", p_o[1], ov_o[1]);
    else n_pass++;
  endtask

  task automatic test_post_adder();
    do_reset();
    A = 18'sd2; B = 18'sd4; C = -40'sd10; C_EN = 1; IN_VALID = 1;
    tick();
    C = 40'sd100; C_EN = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_total++;
      if (p_o[2] !== -40'sd2 || ov_o[2] !== 1'b1) $display("FAIL padd_hold_c: got p=%0d v=%b expected p=-2 v=1", p_o[2], ov_o[2]);
      else n_pass++;
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      A = 18'($urandom); B = 18'($urandom); C = 40'({$urandom, $urandom});
      C_EN = 1'($urandom_range(0, 1)); IN_VALID = 1'($urandom_range(0, 1));
      #1;
      n_total++;
      if (p_o[2] !== post_add(40'(prod(A, B)), c_held) || ov_o[2] !== IN_VALID)
        $display("FAIL padd_rand: got p=%0d v=%b expected p=%0d v=%b", p_o[2], ov_o[2],
                 post_add(40'(prod(A, B)), c_held), IN_VALID);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_accumulate();
    longint exp_seq [7];
    exp_seq = '{8, 9, 10, 11, 12, 12, 12};
    do_reset();
    P_EN = 1; IN_VALID = 1; A = 18'sd1; B = 18'sd1; C = 40'sd7; CDIN_FDBK_SEL = 1;
    for (int k = 0; k < 7; k++) begin
      tick();
      CDIN_FDBK_SEL = 0; C = 40'($urandom);
      if (k >= 4) P_EN = 0;
      n_total++;
      if (p_o[3] !== 40'(exp_seq[k]) || ov_o[3] !== 1'b1)
        $display("FAIL acc_seq step %0d: got p=%0d v=%b expected p=%0d v=1", k, p_o[3], ov_o[3], exp_seq[k]);
      else n_pass++;
    end
    for (int i = 0; i < 16; i++) begin
      A = 18'($urandom); B = 18'($urandom); C = 40'({$urandom, $urandom});
      CDIN_FDBK_SEL = 1'($urandom_range(0, 1)); P_EN = 1'($urandom_range(0, 1));
      IN_VALID = 1'($urandom_range(0, 1));
      tick();
      n_total++;
      if (p_o[3] !== acc_p || ov_o[3] !== acc_v)
        $display("FAIL acc_rand: got p=%0d v=%b expected p=%0d v=%b", p_o[3], ov_o[3], acc_p, acc_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_acc();
    do_reset();
    P_EN = 1; IN_VALID = 1; A = 18'sd3; B = 18'sd3; C = 40'sd40; CDIN_FDBK_SEL = 1;
    tick();
    CDIN_FDBK_SEL = 0;
    tick();
    tick();
    n_total++;
    if (p_o[3] !== acc_p) $display("FAIL acc_before_reset: got %0d expected %0d", p_o[3], acc_p);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (p_o[3] !== 40'sd0 || ov_o[3] !== 1'b0) $display("FAIL async_reset: got p=%0d v=%b expected p=0 v=0", p_o[3], ov_o[3]);
    else n_pass++;
    #1;
    reset = 1'b0;
    model_clear();
    A = 18'sd1; B = 18'sd1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_total++;
      if (p_o[3] !== 40'(k)) $display("FAIL acc_restart step %0d: got %0d expected %0d", k, p_o[3], k);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    longint base;
    longint exp1, exp2;
    base = (longint'(1) <<< 39) - (longint'(1) <<< 34);
`ifdef MAE_ACC_SAT_EN
    exp1 = MAXP;
    exp2 = MAXP;
`else
    exp1 = MINP;
    exp2 = MINP + (longint'(1) <<< 34);
`endif
    do_reset();
    P_EN = 1; IN_VALID = 1; A = '0; B = '0; C = 40'(base); CDIN_FDBK_SEL = 1;
    tick();
    n_total++;
    if (p_o[3] !== 40'(base)) $display("FAIL sat_preload: got %0d expected %0d", p_o[3], base);
    else n_pass++;
`ifdef MAE_ACC_SAT_EN
    n_total++;
    if (sat_o[3] !== 1'b0) $display("FAIL sat_flag_clear: got %b expected 0", sat_o[3]);
    else n_pass++;
`endif
    CDIN_FDBK_SEL = 0; A = -18'sd131072; B = -18'sd131072;
    tick();
    n_total++;
    if (p_o[3] !== 40'(exp1)) $display("FAIL sat_step1: got %0d expected %0d", p_o[3], exp1);
    else n_pass++;
    tick();
    n_total++;
    if (p_o[3] !== 40'(exp2)) $display("FAIL sat_step2: got %0d expected %0d", p_o[3], exp2);
    else n_pass++;
`ifdef MAE_ACC_SAT_EN
    A = '0; B = '0; CDIN_FDBK_SEL = 1; C = '0;
    tick();
    n_total++;
    if (sat_o[3] !== 1'b1) $display("FAIL sat_flag_sticky: got %b expected 1", sat_o[3]);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_comb_multiply();
    test_pipeline();
    test_mixed_enables();
    test_post_adder();
    test_accumulate();
    test_reset_mid_acc();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
